// File: rtl/lapido_isa_pkg.sv
// lapido_isa_pkg: Lapido instruction-set constants shared by the encoder and decoder
package lapido_isa_pkg;

    // Major class in word[31:29]; 011 and 111 are unassigned
    typedef enum logic [2:0] {
        CLS_NOP    = 3'b000,
        CLS_ALU    = 3'b001,
        CLS_CONST  = 3'b010,
        CLS_MEM    = 3'b100,
        CLS_BRANCH = 3'b101,
        CLS_JUMP   = 3'b110
    } class_e;

    // ALU function codes; 10000..11111 form an open extended range
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_MUL    = 5'b00011;
    localparam logic [4:0] ALU_AND    = 5'b00100;
    localparam logic [4:0] ALU_OR     = 5'b00101;
    localparam logic [4:0] ALU_XOR    = 5'b00110;
    localparam logic [4:0] ALU_SHL    = 5'b01000;
    localparam logic [4:0] ALU_SHR    = 5'b01001;
    localparam logic [4:0] ALU_EXT_LO = 5'b10000;

    localparam logic [4:0] CONST_LOADLIT = 5'd0;
    localparam logic [4:0] CONST_LCH     = 5'd1;
    localparam logic [4:0] CONST_LCL     = 5'd2;

    localparam logic [4:0] MEM_LOAD  = 5'd0;
    localparam logic [4:0] MEM_STORE = 5'd1;

    localparam logic [4:0] BR_BEQ = 5'd1;
    localparam logic [4:0] BR_BNE = 5'd2;

    localparam logic [4:0] JMP_JUMP = 5'd0;
    localparam logic [4:0] JMP_JAL  = 5'd1;
    localparam logic [4:0] JMP_JR   = 5'd2;
    localparam logic [4:0] JMP_COND = 5'd16;

    // Jump conditions occupy 0..9 of the 4-bit field
    localparam logic [3:0] COND_MIN = 4'd0;
    localparam logic [3:0] COND_MAX = 4'd9;

    // Field bit positions within the 32-bit word
    localparam int CLASS_HI   = 31;
    localparam int CLASS_LO   = 29;
    localparam int FUNC_HI    = 28;
    localparam int FUNC_LO    = 24;
    localparam int JCOND_FLAG = 28;
    localparam int COND_HI    = 25;
    localparam int COND_LO    = 22;
    localparam int PAYLOAD_HI = 23;
    localparam int JPAY_HI    = 21;

    function automatic logic alu_func_legal(input logic [4:0] f);
        return f[4] || (f inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO exposing its head word combinationally
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : store[rd_ptr[PW-1:0]];

    // Pointer update; reset drops every buffered word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed since the pointers gate visibility
    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic requests into Lapido words and streams them into instruction memory
module instr_encoder
    import lapido_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned ECW   = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_class,
    input  logic [4:0]    req_func,
    input  logic [3:0]    req_cond,
    input  logic [23:0]   req_payload,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_base,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          illegal,
    output logic [ECW-1:0] err_count,
    output logic [AW:0]   words_written,
    output logic          busy
);

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    // Combinational encode and legality check of the presented request
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (req_class)
            CLS_NOP: enc_legal = req_func == '0;
            CLS_ALU: begin
                enc_word  = {CLS_ALU, req_func, req_payload};
                enc_legal = alu_func_legal(req_func);
            end
            CLS_CONST: begin
                enc_word  = {CLS_CONST, 3'b000, req_func[1:0], req_payload};
                enc_legal = req_func <= CONST_LCL;
            end
            CLS_MEM: begin
                enc_word  = {CLS_MEM, 4'b0000, req_func[0], req_payload};
                enc_legal = req_func <= MEM_STORE;
            end
            CLS_BRANCH: begin
                enc_word  = {CLS_BRANCH, req_func[2:0], 2'b00, req_payload};
                enc_legal = req_func == BR_BEQ || req_func == BR_BNE;
            end
            CLS_JUMP: begin
                if (req_func == JMP_COND) begin
                    enc_word  = {CLS_JUMP, 1'b1, 2'b00, req_cond, req_payload[JPAY_HI:0]};
                    enc_legal = req_cond <= COND_MAX && req_payload[PAYLOAD_HI:JPAY_HI+1] == 2'b00;
                end else begin
                    enc_word  = {CLS_JUMP, 1'b0, req_func[3:0], req_payload};
                    enc_legal = req_func <= JMP_JR;
                end
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc_legal;
    assign busy      = !empty;
    assign mem_we    = busy;
    assign pop       = mem_we && mem_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (enc_word),
        .pop     (pop),
        .rdata   (mem_wdata),
        .full    (full),
        .empty   (empty)
    );

    // One-cycle illegal pulse and saturating reject counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal   <= 1'b0;
            err_count <= '0;
        end else begin
            illegal <= accept && !enc_legal;
            if (accept && !enc_legal && err_count != '1) err_count <= err_count + 1'b1;
        end
    end

    // Write address and completed-write count; a load overrides a coinciding pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr      <= '0;
            words_written <= '0;
        end else if (addr_load) begin
            mem_addr      <= addr_base;
            words_written <= '0;
        end else if (pop) begin
            mem_addr      <= mem_addr + 1'b1;
            words_written <= words_written + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [4:0]  req_func;
    logic [3:0]  req_cond;
    logic [23:0] req_payload;
    logic        addr_load;
    logic [7:0]  addr_base;
    logic        mem_we;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        illegal;
    logic [7:0]  err_count;
    logic [8:0]  words_written;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    instr_encoder #(.DEPTH(4), .AW(8), .ECW(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_class     (req_class),
        .req_func      (req_func),
        .req_cond      (req_cond),
        .req_payload   (req_payload),
        .addr_load     (addr_load),
        .addr_base     (addr_base),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .illegal       (illegal),
        .err_count     (err_count),
        .words_written (words_written),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every write that will complete on the coming rising edge
    always @(negedge clock) begin
        if (reset_n && mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] f, input logic [3:0] cd, input logic [23:0] p);
        int n;
        req_class   = c;
        req_func    = f;
        req_cond    = cd;
        req_payload = p;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check("send_ready_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic enc_case(input string tag, input logic [2:0] c, input logic [4:0] f, input logic [3:0] cd,
                            input logic [23:0] p, input logic legal, input logic [31:0] word);
        send(c, f, cd, p);
        if (legal) begin
            check({tag, "_we"}, 32'(mem_we), 32'd1);
            check({tag, "_word"}, mem_wdata, word);
        end else begin
            check({tag, "_illegal"}, 32'(illegal), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd0);
        end
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_class   = '0;
        req_func    = '0;
        req_cond    = '0;
        req_payload = '0;
        addr_load   = 1'b0;
        addr_base   = '0;
        mem_ready   = 1'b0;
        #2;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // single ALU add
        mem_ready = 1'b1;
        wa.delete();
        wd.delete();
        send(3'b001, 5'd0, 4'd0, 24'h000123);
        check("t1_we", 32'(mem_we), 32'd1);
        check("t1_wdata", mem_wdata, 32'h20000123);
        check("t1_addr", 32'(mem_addr), 32'd0);
        tick();
        check("t1_ww", 32'(words_written), 32'd1);
        check("t1_addr_after", 32'(mem_addr), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_nwr", 32'(wa.size()), 32'd1);
        check("t1_wr_data", wd[0], 32'h20000123);

        // store then conditional jump
        wa.delete();
        wd.delete();
        send(3'b100, 5'd1, 4'd0, 24'h00ABCD);
        send(3'b110, 5'd16, 4'd4, 24'h0003FF);
        tick();
        tick();
        check("t2_nwr", 32'(wa.size()), 32'd2);
        check("t2_d0", wd[0], 32'h8100ABCD);
        check("t2_a0", 32'(wa[0]), 32'd1);
        check("t2_d1", wd[1], 32'hD10003FF);
        check("t2_a1", 32'(wa[1]), 32'd2);
        check("t2_ww", 32'(words_written), 32'd3);

        // three illegal requests then beq
        wa.delete();
        wd.delete();
        send(3'b001, 5'b00010, 4'd0, 24'h0);
        check("t3_ill1", 32'(illegal), 32'd1);
        check("t3_err1", 32'(err_count), 32'd1);
        send(3'b111, 5'd0, 4'd0, 24'h0);
        check("t3_ill2", 32'(illegal), 32'd1);
        send(3'b110, 5'd16, 4'd10, 24'h0);
        check("t3_ill3", 32'(illegal), 32'd1);
        check("t3_err3", 32'(err_count), 32'd3);
        tick();
        check("t3_ill_clear", 32'(illegal), 32'd0);
        check("t3_nwr", 32'(wa.size()), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        send(3'b101, 5'd1, 4'd0, 24'h0);
        tick();
        check("t3_beq_nwr", 32'(wa.size()), 32'd1);
        check("t3_beq", wd[0], 32'hA4000000);
        check("t3_beq_addr", 32'(wa[0]), 32'd3);

        // backpressure with a full FIFO
        addr_base = 8'h40;
        addr_load = 1'b1;
        tick();
        addr_load = 1'b0;
        check("t4_load_addr", 32'(mem_addr), 32'h40);
        check("t4_load_ww", 32'(words_written), 32'd0);
        mem_ready = 1'b0;
        wa.delete();
        wd.delete();
        for (int i = 0; i < 4; i++) send(3'b001, 5'd0, 4'd0, 24'(i + 1));
        check("t4_full_ready", 32'(req_ready), 32'd0);
        check("t4_head", mem_wdata, 32'h20000001);
        check("t4_head_addr", 32'(mem_addr), 32'h40);
        req_payload = 24'd5;
        req_valid   = 1'b1;
        repeat (3) tick();
        check("t4_hold_ready", 32'(req_ready), 32'd0);
        check("t4_hold_head", mem_wdata, 32'h20000001);
        check("t4_hold_addr", 32'(mem_addr), 32'h40);
        check("t4_hold_we", 32'(mem_we), 32'd1);
        check("t4_hold_nwr", 32'(wa.size()), 32'd0);
        mem_ready = 1'b1;
        send(3'b001, 5'd0, 4'd0, 24'd5);
        repeat (6) tick();
        check("t4_nwr", 32'(wa.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_d%0d", i), wd[i], 32'h20000001 + 32'(i));
            check($sformatf("t4_a%0d", i), 32'(wa[i]), 32'h40 + 32'(i));
        end
        check("t4_ww", 32'(words_written), 32'd5);

        // address wrap after load
        addr_base = 8'hFE;
        addr_load = 1'b1;
        tick();
        addr_load = 1'b0;
        wa.delete();
        wd.delete();
        for (int i = 0; i < 3; i++) send(3'b110, 5'd1, 4'd0, 24'h0);
        repeat (3) tick();
        check("t5_nwr", 32'(wa.size()), 32'd3);
        check("t5_a0", 32'(wa[0]), 32'hFE);
        check("t5_a1", 32'(wa[1]), 32'hFF);
        check("t5_a2", 32'(wa[2]), 32'h00);
        for (int i = 0; i < 3; i++) check($sformatf("t5_d%0d", i), wd[i], 32'hC1000000);
        check("t5_ww", 32'(words_written), 32'd3);
        check("t5_addr", 32'(mem_addr), 32'd1);

        // addr_load keeps FIFO contents and wins over a coinciding pop
        mem_ready = 1'b0;
        send(3'b001, 5'd0, 4'd0, 24'd7);
        addr_base = 8'h10;
        addr_load = 1'b1;
        tick();
        check("t5_keep_busy", 32'(busy), 32'd1);
        check("t5_keep_word", mem_wdata, 32'h20000007);
        check("t5_keep_addr", 32'(mem_addr), 32'h10);
        addr_base = 8'h20;
        mem_ready = 1'b1;
        tick();
        addr_load = 1'b0;
        check("t5_prio_addr", 32'(mem_addr), 32'h20);
        check("t5_prio_ww", 32'(words_written), 32'd0);
        check("t5_prio_busy", 32'(busy), 32'd0);

        // asynchronous reset with buffered words
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'b001, 5'd0, 4'd0, 24'(i));
        check("t6_busy_pre", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_we", 32'(mem_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_err", 32'(err_count), 32'd0);
        tick();
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        check("t6_ww", 32'(words_written), 32'd0);

        // encoding and legality table
        enc_case("nop",      3'b000, 5'd0,     4'd0,  24'h000000, 1'b1, 32'h00000000);
        enc_case("alu_shr",  3'b001, 5'b01001, 4'd0,  24'hABCDEF, 1'b1, 32'h29ABCDEF);
        enc_case("alu_ext",  3'b001, 5'b11111, 4'd0,  24'h000000, 1'b1, 32'h3F000000);
        enc_case("loadlit",  3'b010, 5'd0,     4'd0,  24'h123456, 1'b1, 32'h40123456);
        enc_case("lch",      3'b010, 5'd1,     4'd0,  24'hFFFFFF, 1'b1, 32'h41FFFFFF);
        enc_case("lcl",      3'b010, 5'd2,     4'd0,  24'h000001, 1'b1, 32'h42000001);
        enc_case("load",     3'b100, 5'd0,     4'd0,  24'h123456, 1'b1, 32'h80123456);
        enc_case("bne",      3'b101, 5'd2,     4'd0,  24'h00000F, 1'b1, 32'hA800000F);
        enc_case("jump",     3'b110, 5'd0,     4'd0,  24'h000010, 1'b1, 32'hC0000010);
        enc_case("jr",       3'b110, 5'd2,     4'd15, 24'hFFFFFF, 1'b1, 32'hC2FFFFFF);
        enc_case("jcond9",   3'b110, 5'd16,    4'd9,  24'h3FFFFF, 1'b1, 32'hD27FFFFF);
        enc_case("nop_f1",   3'b000, 5'd1,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("alu_7",    3'b001, 5'b00111, 4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("alu_10",   3'b001, 5'b01010, 4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("const_3",  3'b010, 5'd3,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("mem_2",    3'b100, 5'd2,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("br_0",     3'b101, 5'd0,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("br_3",     3'b101, 5'd3,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("jmp_3",    3'b110, 5'd3,     4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("jmp_17",   3'b110, 5'd17,    4'd0,  24'h0, 1'b0, 32'h0);
        enc_case("jc_pay",   3'b110, 5'd16,    4'd4,  24'h400000, 1'b0, 32'h0);
        enc_case("cls_011",  3'b011, 5'd0,     4'd0,  24'h0, 1'b0, 32'h0);
        check("t7_err", 32'(err_count), 32'd11);
        check("t7_ww", 32'(words_written), 32'd11);

        // error counter saturation
        for (int i = 0; i < 250; i++) send(3'b111, 5'd0, 4'd0, 24'h0);
        check("sat_err", 32'(err_count), 32'd255);
        check("sat_ill", 32'(illegal), 32'd1);
        check("sat_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
